aes_req_sched: RTL
==================

Name: aes_req_sched

Overview:
- Round-robin scheduler that shares one iterative AES-128 encryption core between NREQ independent requesters.
- Accepts one key+plaintext job at a time over valid/ready, issues the core load pulse, and waits for the core's done pulse or a watchdog timeout.
- Returns the ciphertext to the originating requester over a per-requester valid/ready response channel.
- Sits between client blocks and the cipher core; the core is never loaded while busy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of grant index (derived, not overridden).
- TIMEOUT, 32, max cycles in WAIT before the job is aborted with error (must exceed core latency of 12).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester job accept (one-hot or zero).
- req_key  in  NREQ*128  packed keys; requester i at [i*128 +: 128].
- req_text  in  NREQ*128  packed plaintexts, same packing.
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero).
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_data  out  128  ciphertext, shared by all requesters.
- rsp_err  out  1  1 = job timed out, rsp_data is zero.
- core_ld  out  1  one-cycle load pulse to core.
- core_key  out  128  key to core.
- core_text  out  128  plaintext to core.
- core_done  in  1  core completion pulse.
- core_text_out  in  128  core ciphertext, valid when core_done=1.
- busy  out  1  state != IDLE.
- grant_id  out  IDW  index of current/last granted requester.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, core_ld=0, core_key=0, core_text=0, busy=0, wdog=0, grant_id=NREQ-1, so requester 0 wins first. Reset mid-job drops the job silently with no response.
- States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - Combinational round-robin pick among req_valid, searching from grant_id+1 with wrap to 0.
  - req_ready[winner]=1 in the same cycle; req_ready=0 when no req_valid.
  - On handshake: capture req_key/req_text of winner into core_key/core_text, set grant_id=winner, go LOAD.
- LOAD: core_ld=1 for exactly one cycle; wdog cleared; go WAIT. core_key/core_text stay stable from capture until the next IDLE handshake.
- WAIT:
  - core_done=1: rsp_data<=core_text_out, rsp_err<=0, go RESP.
  - Otherwise wdog increments; when wdog==TIMEOUT-1 without core_done: rsp_data<=0, rsp_err<=1, go RESP.
  - If core_done and the timeout hit occur in the same cycle, core_done wins.
- RESP: rsp_valid[grant_id]=1; rsp_data/rsp_err held; on rsp_ready[grant_id]=1 go IDLE.
- Ignored inputs:
  - rsp_ready of other requesters is ignored.
  - core_done outside WAIT is ignored and never captured.
  - req_valid outside IDLE is ignored; req_ready=0 outside IDLE.
- Latency: handshake at cycle T -> core_ld at T+1 -> core_done at T+13 (core latency 12) -> rsp_valid at T+14. Next accept no earlier than the cycle after rsp handshake (IDLE).
- Fairness: the requester just served has lowest priority next arbitration; any continuously-valid requester is served within NREQ jobs.
- Requester may drop req_valid before acceptance; no job is recorded.

Test Plan:
- Single job, FIPS-197 vector: req 0, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, rsp_ready=1 -> core_ld one pulse at T+1, rsp_valid[0] at T+14, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- All NREQ=4 requesters valid continuously after reset -> grant order 0,1,2,3,0. Each rsp_valid is one-hot on the granted index, and exactly one core_ld occurs per job.
- Response backpressure: rsp_ready[0]=0 for 20 cycles after rsp_valid -> rsp_valid/rsp_data held stable, busy=1, no req_ready, no core_ld; accept -> IDLE next cycle.
- Timeout: core_done tied 0 -> rsp_valid at T+1+TIMEOUT with rsp_err=1, rsp_data=0. A later stray core_done in IDLE or RESP has no effect.
- Reset mid-WAIT: rst=0 at T+6 -> next cycle all outputs at reset values, grant_id=NREQ-1. A new request after reset is served normally with correct ciphertext.
- Stray core_done in IDLE, and simultaneous core_done with timeout expiry -> stray ignored; simultaneous case returns core data with rsp_err=0.

Source files
------------

// File: rtl/aes_req_sched.sv
// Round-robin scheduler sharing one iterative AES-128 core between NREQ requesters.
// One job in flight: accept, load core, wait for done or watchdog, return result.
module aes_req_sched #(
    parameter int unsigned NREQ    = 4,
    localparam int unsigned IDW    = $clog2(NREQ),
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_key,
    input  logic [NREQ*128-1:0] req_text,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [127:0]        rsp_data,
    output logic                rsp_err,
    output logic                core_ld,
    output logic [127:0]        core_key,
    output logic [127:0]        core_text,
    input  logic                core_done,
    input  logic [127:0]        core_text_out,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    localparam int unsigned WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     text_q, text_d;
    logic [127:0]     data_q, data_d;
    logic             err_q, err_d;
    logic             ld_q, ld_d;
    logic [WDW-1:0]   wdog_q, wdog_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [127:0]     key_sel;
    logic [127:0]     text_sel;
    int unsigned      cand;

    // Search starts just after the last grant, so the last-served requester ranks lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(grant_q) + off) % NREQ;
            if (!win_found && req_valid[IDW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        key_sel  = '0;
        text_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) begin
                key_sel  = req_key[i*128 +: 128];
                text_sel = req_text[i*128 +: 128];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        key_d   = key_q;
        text_d  = text_q;
        data_d  = data_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        ld_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    key_d   = key_sel;
                    text_d  = text_sel;
                    grant_d = win_idx;
                    ld_d    = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                // A done arriving on the expiry cycle still delivers real data.
                if (core_done) begin
                    data_d  = core_text_out;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (wdog_d == WDW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready[grant_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= IDW'(NREQ - 1);
            key_q   <= '0;
            text_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            key_q   <= key_d;
            text_q  <= text_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            wdog_q  <= wdog_d;
        end
    end

    // Ready is masked during reset so no requester sees a handshake that gets dropped.
    assign req_ready = (rst && state_q == StIdle && win_found) ? (NREQ'(1) << win_idx) : '0;
    assign rsp_valid = (state_q == StResp) ? (NREQ'(1) << grant_q) : '0;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign core_ld   = ld_q;
    assign core_key  = key_q;
    assign core_text = text_q;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_q;

endmodule
